// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, parity-type constants and vote helper for the UART receiver.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter with a 3-sample majority vote around mid-bit.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE = 8,
   parameter int EW       = $clog2(PRESCALE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic          rx_i,
   output logic [EW-1:0] edge_o,
   output logic          bit_o,
   output logic          done_o
);

   localparam logic [EW-1:0] S0   = EW'(PRESCALE / 2 - 1);
   localparam logic [EW-1:0] S1   = EW'(PRESCALE / 2);
   localparam logic [EW-1:0] S2   = EW'(PRESCALE / 2 + 1);
   localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);

   logic [EW-1:0] edge_q, edge_d;
   logic [1:0]    smp_q, smp_d;
   logic          bit_q, bit_d;

   // The vote is registered at the third sample, so it is usable from count PRESCALE/2+2 onward.
   always_comb begin
      edge_d = (!en_i || edge_q == LAST) ? '0 : edge_q + EW'(1);
      smp_d  = {(en_i && edge_q == S1) ? rx_i : smp_q[1], (en_i && edge_q == S0) ? rx_i : smp_q[0]};
      bit_d  = (en_i && edge_q == S2) ? maj3(smp_q[0], smp_q[1], rx_i) : bit_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_q <= '0;
         smp_q  <= 2'b11;
         bit_q  <= 1'b1;
      end else begin
         edge_q <= edge_d;
         smp_q  <= smp_d;
         bit_q  <= bit_d;
      end
   end

   assign edge_o = edge_q;
   assign bit_o  = bit_q;
   assign done_o = en_i && edge_q == LAST;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional even/odd parity and stop-bit checking.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int width    = 8,
   parameter int PRESCALE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RX_in,
   input  logic             Par_en,
   input  logic             Par_type,
   output logic [width-1:0] P_data,
   output logic             Data_valid,
   output logic             Par_err,
   output logic             Stp_err
);

   localparam int EW = $clog2(PRESCALE);
   localparam int BW = (width > 1) ? $clog2(width) : 1;
   localparam logic [EW-1:0] STOP_CHK = EW'(PRESCALE / 2 + 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);

   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic             rx_s, run, bit_v, bit_end;
   logic [EW-1:0]    edge_cnt;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic [width-1:0] shift_q, shift_d, pdata_q, pdata_d;
   logic             pen_q, pen_d, ptype_q, ptype_d, perr_q, perr_d;
   logic             dv_q, dv_d, pe_q, pe_d, se_q, se_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b11;
      else sync_q <= {sync_q[0], RX_in};
   end

   assign rx_s = sync_q[1];
   assign run  = state_q != IDLE && state_q != WAIT_HIGH;

   uart_rx_sampler #(.PRESCALE(PRESCALE), .EW(EW)) u_sampler (
      .clk    (clk),
      .rst    (rst),
      .en_i   (run),
      .rx_i   (rx_s),
      .edge_o (edge_cnt),
      .bit_o  (bit_v),
      .done_o (bit_end)
   );

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      pdata_d = pdata_q;
      pen_d   = pen_q;
      ptype_d = ptype_q;
      perr_d  = perr_q;
      dv_d    = 1'b0;
      pe_d    = 1'b0;
      se_d    = 1'b0;
      case (state_q)
         IDLE: if (!rx_s) begin
            state_d = START;
            bcnt_d  = '0;
            perr_d  = 1'b0;
            pen_d   = Par_en;
            ptype_d = Par_type;
         end
         START: if (bit_end) state_d = bit_v ? IDLE : DATA;
         DATA: if (bit_end) begin
            shift_d = {bit_v, shift_q[width-1:1]};
            bcnt_d  = bcnt_q + BW'(1);
            if (bcnt_q == BIT_LAST) state_d = pen_q ? PARITY : STOP;
         end
         PARITY: if (bit_end) begin
            perr_d  = bit_v != (^shift_q ^ (ptype_q == PAR_ODD));
            state_d = STOP;
         end
         // Decided mid stop bit so an immediately following start edge is not missed.
         STOP: if (edge_cnt == STOP_CHK) begin
            pe_d    = perr_q;
            se_d    = !bit_v;
            dv_d    = bit_v && !perr_q;
            pdata_d = (bit_v && !perr_q) ? shift_q : pdata_q;
            state_d = bit_v ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: if (rx_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         shift_q <= '0;
         pdata_q <= '0;
         pen_q   <= 1'b0;
         ptype_q <= PAR_EVEN;
         perr_q  <= 1'b0;
         dv_q    <= 1'b0;
         pe_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         pdata_q <= pdata_d;
         pen_q   <= pen_d;
         ptype_q <= ptype_d;
         perr_q  <= perr_d;
         dv_q    <= dv_d;
         pe_q    <= pe_d;
         se_q    <= se_d;
      end
   end

   assign P_data     = pdata_q;
   assign Data_valid = dv_q;
   assign Par_err    = pe_q;
   assign Stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level scoreboard bench for uart_rx with directed and randomized serial traffic.
module tb_uart_rx;

   localparam int P = 8;
   localparam int W = 8;

   logic         clk = 1'b0, rst = 1'b0, RX_in = 1'b1, Par_en = 1'b0, Par_type = 1'b0;
   logic [W-1:0] P_data;
   logic         Data_valid, Par_err, Stp_err;

   int total = 0, bad = 0, cyc = 0;
   int n_dv = 0, n_pe = 0, n_se = 0;
   logic         prev_any = 1'b0, any_p;
   logic [W-1:0] held = '0;

   typedef struct {
      logic         dv;
      logic         pe;
      logic         se;
      logic [W-1:0] data;
      int           stop_cyc;
   } ev_t;
   ev_t q[$];
   ev_t ev;

   uart_rx #(.width(W), .PRESCALE(P)) dut (
      .clk        (clk),
      .rst        (rst),
      .RX_in      (RX_in),
      .Par_en     (Par_en),
      .Par_type   (Par_type),
      .P_data     (P_data),
      .Data_valid (Data_valid),
      .Par_err    (Par_err),
      .Stp_err    (Stp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Parity rule on the line: ones in data plus parity bit must be even (type 0) or odd (type 1).
   function automatic logic exp_pe(input logic [W-1:0] d, input logic pbit, input logic ptype);
      return (($countones(d) + int'(pbit)) % 2) != int'(ptype);
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic v, input int g = -1);
      for (int i = 0; i < P; i++) begin
         RX_in = (i == g) ? ~v : v;
         tick();
      end
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic ptype, input logic pflip,
                             input logic stp, input int gbit, input int goff, input int gap);
      ev_t  e;
      logic pbit;
      pbit = (($countones(d) % 2) == 1) ^ ptype ^ pflip;
      Par_en   = pen;
      Par_type = ptype;
      send_bit(1'b0);
      for (int b = 0; b < W; b++) begin
         send_bit(d[b], (b == gbit) ? goff : -1);
         if (b == 1) begin
            Par_en   = 1'($urandom);
            Par_type = 1'($urandom);
         end
      end
      if (pen) send_bit(pbit);
      e.data     = d;
      e.pe       = pen && exp_pe(d, pbit, ptype);
      e.se       = !stp;
      e.dv       = !e.pe && !e.se;
      e.stop_cyc = cyc;
      q.push_back(e);
      send_bit(stp);
      RX_in = 1'b1;
      tick(gap);
   endtask

   task automatic abort_frame(input logic [W-1:0] d, input int nbits);
      Par_en = 1'b0;
      send_bit(1'b0);
      for (int b = 0; b < nbits; b++) send_bit(d[b]);
      tick(3);
      rst = 1'b0;
      tick(3);
      RX_in = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(4);
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("reset_outputs", {21'd0, P_data, Data_valid, Par_err, Stp_err}, 32'd0);
         held     = '0;
         prev_any = 1'b0;
      end else begin
         any_p = Data_valid | Par_err | Stp_err;
         if (any_p) begin
            chk("pulse_spacing", prev_any, 1'b0);
            if (q.size() == 0) chk("unexpected_pulse", any_p, 1'b0);
            else begin
               ev = q.pop_front();
               chk("data_valid", Data_valid, ev.dv);
               chk("par_err", Par_err, ev.pe);
               chk("stp_err", Stp_err, ev.se);
               chk("pulse_window", ((cyc - ev.stop_cyc) >= P / 2 && (cyc - ev.stop_cyc) <= P + 4) ? 1 : 0, 1);
               if (ev.dv) held = ev.data;
            end
            n_dv += int'(Data_valid);
            n_pe += int'(Par_err);
            n_se += int'(Stp_err);
         end else if (q.size() != 0 && cyc > q[0].stop_cyc + P + 4) begin
            chk("missing_pulse", any_p, 1'b1);
            ev = q.pop_front();
         end
         chk("p_data", P_data, held);
         prev_any = any_p;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its end, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [W-1:0] d;
      logic         pen, ptype, pflip, stp;
      int           gb, goff, gap;
      tick(3);
      rst = 1'b1;
      tick(4);
      chk("reset_pdata", P_data, 8'h00);
      chk("model_even_ok", exp_pe(8'hA5, 1'b0, 1'b0), 1'b0);
      chk("model_even_bad", exp_pe(8'hA5, 1'b1, 1'b0), 1'b1);
      chk("model_odd_ok", exp_pe(8'h07, 1'b0, 1'b1), 1'b0);
      chk("model_odd_bad", exp_pe(8'h07, 1'b1, 1'b1), 1'b1);

      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 12);
      chk("a5_pdata", P_data, 8'hA5);
      chk("a5_dv_count", n_dv, 1);

      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 12);
      chk("parerr_pdata_kept", P_data, 8'hA5);
      chk("parerr_count", n_pe, 1);
      chk("parerr_no_dv", n_dv, 1);

      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 0);
      RX_in = 1'b0;
      tick(12 * P);
      RX_in = 1'b1;
      tick(12);
      chk("stperr_count", n_se, 1);
      chk("stperr_pdata_kept", P_data, 8'hA5);

      RX_in = 1'b0;
      tick(2);
      RX_in = 1'b1;
      tick(P + 6);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 12);
      chk("after_glitch_pdata", P_data, 8'h5A);
      chk("after_glitch_dv_count", n_dv, 2);

      send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 3, P / 2 + 1, 0);
      send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 12);
      chk("b2b_pdata", P_data, 8'hC3);
      chk("b2b_dv_count", n_dv, 4);

      abort_frame(8'hFF, 3);
      chk("abort_pdata", P_data, 8'h00);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 12);
      chk("post_reset_pdata", P_data, 8'h81);
      chk("post_reset_dv_count", n_dv, 5);

      for (int k = 0; k < 60; k++) begin
         d     = W'($urandom);
         pen   = 1'($urandom);
         ptype = 1'($urandom);
         pflip = pen && ($urandom_range(0, 4) == 0);
         stp   = $urandom_range(0, 7) != 0;
         gb    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
         goff  = int'($urandom_range(0, P - 1));
         gap   = stp ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 8));
         send_frame(d, pen, ptype, pflip, stp, gb, goff, gap);
      end
      tick(3 * P);
      chk("scoreboard_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
